// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential approximate array divider.
// Holds the FSM state encoding, row-counter sizing and default row mask.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rows approximated by default: the two least significant quotient rows.
    localparam logic [7:0] DEF_APPROX_MASK = 8'b0000_0011;

    // Width of a counter that walks rows W-1 down to 0.
    function automatic int row_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_row_sub.sv
// One restoring-array row: W-column borrow chain subtracting y from x.
// Columns below APPROX_COLS switch to the approximate cell when approx is set.
module div_row_sub #(
    parameter int W           = 8,
    parameter int APPROX_COLS = W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         approx,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic br;

    // Ripple the borrow from column 0 upward, picking the cell per column.
    always_comb begin
        diff = '0;
        br   = 1'b0;
        for (int c = 0; c < W; c++) begin
            if (approx && (c < APPROX_COLS)) begin
                diff[c] = y[c];
                br      = ~x[c] & ~br;
            end else begin
                diff[c] = x[c] ^ y[c] ^ br;
                br      = (~x[c] & y[c]) | (~(x[c] ^ y[c]) & br);
            end
        end
        bout = br;
    end

endmodule

// File: rtl/seq_approx_array_divider.sv
// Iterative restoring divider, one array row per clock, MSB row first.
// Optional macro DIV_ZERO_CHECK_EN short-circuits divide-by-zero to DONE.
module seq_approx_array_divider
    import div_pkg::*;
#(
    parameter int           W           = 8,
    parameter logic [W-1:0] APPROX_MASK = W'(DEF_APPROX_MASK),
    parameter int           APPROX_COLS = W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] n,
    input  logic [W-1:0]   d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           ovf,
    output logic           dbz
);

    localparam int KW = row_cnt_w(W);

    state_t        state;
    logic [W-1:0]  dv;
    logic [W:0]    p;
    logic [W-2:0]  nlo;
    logic [KW-1:0] k;
    logic [KW-1:0] km1;
    logic          dbz_q;

    logic [W-1:0]  diff;
    logic          bout;
    logic          qbit;
    logic [W-1:0]  rem;
    logic          zero_div;

    div_row_sub #(
        .W          (W),
        .APPROX_COLS(APPROX_COLS)
    ) u_row (
        .x     (p[W-1:0]),
        .y     (dv),
        .approx(APPROX_MASK[k]),
        .diff  (diff),
        .bout  (bout)
    );

    // Resolve the current row's quotient bit and restored remainder.
    always_comb begin
        qbit = p[W] | ~bout;
        rem  = qbit ? diff : p[W-1:0];
        km1  = k - 1'b1;
    end

`ifdef DIV_ZERO_CHECK_EN
    assign zero_div = (d == '0);
`else
    assign zero_div = 1'b0;
`endif

    assign dbz = dbz_q;

    // Handshake FSM, row sequencing and all result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            ovf       <= 1'b0;
            dbz_q     <= 1'b0;
            dv        <= '0;
            p         <= '0;
            nlo       <= '0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        dv       <= d;
                        in_ready <= 1'b0;
                        if (zero_div) begin
                            q         <= '1;
                            r         <= n[W-1:0];
                            ovf       <= 1'b1;
                            dbz_q     <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            p     <= n[2*W-1:W-1];
                            nlo   <= n[W-2:0];
                            k     <= KW'(W - 1);
                            q     <= '0;
                            ovf   <= (n[2*W-1:W] >= d);
                            dbz_q <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    q[k] <= qbit;
                    if (k != '0) begin
                        p <= {rem, nlo[km1]};
                        k <= km1;
                    end else begin
                        r         <= rem;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
